// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and requester indices for the memory port arbiter
package mem_arb_pkg;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic [1:0] owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshake bundle plus the single memory port
interface mem_port_arbiter_if #(parameter int AW = 12, parameter int DW = 12);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      done;
  logic [2:0]      err;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_write_enable;
  logic [DW-1:0]   mem_data_in;
  logic [DW-1:0]   mem_data_out;
  modport slave (
    input  req, we, addr, wdata, mem_data_out,
    output gnt, done, err, rdata, busy, mem_addr, mem_write_enable, mem_data_in
  );
  modport master (
    output req, we, addr, wdata, mem_data_out,
    input  gnt, done, err, rdata, busy, mem_addr, mem_write_enable, mem_data_in
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fixed-priority winner select; starved data/fetch jump ahead of everything but the loader
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       starved_data_i,
  input  logic       starved_fetch_i,
  output logic [2:0] win_o,
  output owner_t     idx_o
);
  always_comb begin
    win_o = req_i[REQ_LOAD]                     ? 3'b100 :
            (req_i[REQ_DATA] && starved_data_i)   ? 3'b010 :
            (req_i[REQ_FETCH] && starved_fetch_i) ? 3'b001 :
            req_i[REQ_DATA]                     ? 3'b010 :
            req_i[REQ_FETCH]                    ? 3'b001 : 3'b000;
    idx_o = win_o[2] ? owner_t'(REQ_LOAD) : win_o[1] ? owner_t'(REQ_DATA) : owner_t'(REQ_FETCH);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory among fetch, data and loader,
// one 3-cycle access (IDLE -> ACCESS -> RESP) at a time
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 12,
  parameter int DW           = 12,
  parameter int MEM_SIZE     = 255,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t        state_q, state_d;
  owner_t        owner_q, win_idx;
  logic [2:0]    win;
  logic [3:0]    starve_data_q, starve_data_d, starve_fetch_q, starve_fetch_d;
  logic [AW-1:0] addr_q, sel_addr;
  logic [DW-1:0] wdata_q, sel_wdata;
  logic          mwe_q, wr_q, oor_q, sel_oor, arb;

  mem_arb_pick u_pick (
    .req_i          (bus.req),
    .starved_data_i (starve_data_q == LIM),
    .starved_fetch_i(starve_fetch_q == LIM),
    .win_o          (win),
    .idx_o          (win_idx)
  );

  always_comb begin
    arb       = state_q == IDLE && |bus.req;
    sel_addr  = bus.addr[int'(win_idx)*AW +: AW];
    sel_wdata = bus.wdata[int'(win_idx)*DW +: DW];
    sel_oor   = 32'(sel_addr) >= MEM_SIZE;
    // counters only move in IDLE; a low req there clears them, a lost arbitration saturates up
    starve_data_d  = state_q != IDLE ? starve_data_q :
                     (bus.req[REQ_DATA] && !win[REQ_DATA]) ?
                     (starve_data_q == LIM ? LIM : starve_data_q + 4'd1) : 4'd0;
    starve_fetch_d = state_q != IDLE ? starve_fetch_q :
                     (bus.req[REQ_FETCH] && !win[REQ_FETCH]) ?
                     (starve_fetch_q == LIM ? LIM : starve_fetch_q + 4'd1) : 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE ? (|bus.req ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q        <= owner_t'(REQ_FETCH);
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_q           <= 1'b0;
      mwe_q          <= 1'b0;
      oor_q          <= 1'b0;
      starve_data_q  <= 4'd0;
      starve_fetch_q <= 4'd0;
    end else begin
      starve_data_q  <= starve_data_d;
      starve_fetch_q <= starve_fetch_d;
      if (arb) begin
        owner_q <= win_idx;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wr_q    <= bus.we[win_idx];
        mwe_q   <= bus.we[win_idx] && !sel_oor;
        oor_q   <= sel_oor;
      end else if (state_q == ACCESS) begin
        mwe_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.busy             = state_q != IDLE;
    bus.gnt              = state_q == ACCESS ? 3'b001 << owner_q : 3'b000;
    bus.done             = state_q == RESP ? 3'b001 << owner_q : 3'b000;
    bus.err              = (state_q == RESP && oor_q) ? 3'b001 << owner_q : 3'b000;
    bus.rdata            = (state_q == RESP && !oor_q && !wr_q) ? bus.mem_data_out : '0;
    bus.mem_addr         = addr_q;
    bus.mem_data_in      = wdata_q;
    bus.mem_write_enable = mwe_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random accesses checked against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int MSZ = 255;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_port_arbiter_if #(.AW(12), .DW(12)) bus ();
  mem_port_arbiter #(.AW(12), .DW(12), .MEM_SIZE(MSZ), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;

  logic [11:0] tb_mem [4096];
  logic [11:0] ref_mem[4096];
  int errors = 0, checks = 0, mwe_cnt = 0;
  int m_phase = 0, m_owner = 0, m_we = 0, m_oor = 0, cnt_d = 0, cnt_f = 0;
  logic [11:0] m_addr = '0, m_wd = '0;
  logic [11:0] rd;
  logic [2:0]  er;
  int mwe_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory behaves as a 1-cycle synchronous read/write RAM sampling the port at the edge
  task automatic edge_mem();
    logic        wen;
    logic [11:0] ma, md;
    wen = bus.mem_write_enable;
    ma  = bus.mem_addr;
    md  = bus.mem_data_in;
    @(posedge clk);
    if (wen) tb_mem[ma] = md;
    bus.mem_data_out = tb_mem[ma];
  endtask

  task automatic check_cycle();
    logic [2:0] one;
    one = 3'b001 << m_owner;
    check("busy", 32'(bus.busy), 32'(m_phase != 0));
    check("gnt", 32'(bus.gnt), m_phase == 1 ? 32'(one) : 0);
    check("done", 32'(bus.done), m_phase == 2 ? 32'(one) : 0);
    check("err", 32'(bus.err), (m_phase == 2 && m_oor != 0) ? 32'(one) : 0);
    check("rdata", 32'(bus.rdata), (m_phase == 2 && m_we == 0 && m_oor == 0) ? 32'(ref_mem[m_addr]) : 0);
    check("mwe", 32'(bus.mem_write_enable), 32'(m_phase == 1 && m_we != 0 && m_oor == 0));
    if (m_phase == 1) check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    if (bus.mem_write_enable) mwe_cnt++;
  endtask

  task automatic model_next(input logic [2:0] r, input logic [2:0] w, input logic [35:0] a, input logic [35:0] d);
    int win;
    bit arb;
    if (m_phase == 0) begin
      arb = r != 0;
      win = -1;
      if (arb) begin
        win = r[2] ? 2 : (r[1] && cnt_d == LIM) ? 1 : (r[0] && cnt_f == LIM) ? 0 : r[1] ? 1 : 0;
        m_owner = win;
        m_addr  = a[win*12 +: 12];
        m_wd    = d[win*12 +: 12];
        m_we    = int'(w[win]);
        m_oor   = int'(m_addr >= 12'(MSZ));
        m_phase = 1;
      end
      cnt_d = (r[1] && win != 1) ? ((cnt_d + 1 > LIM) ? LIM : cnt_d + 1) : 0;
      cnt_f = (r[0] && win != 0) ? ((cnt_f + 1 > LIM) ? LIM : cnt_f + 1) : 0;
    end else if (m_phase == 1) begin
      if (m_we != 0 && m_oor == 0) ref_mem[m_addr] = m_wd;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [35:0] a, input logic [35:0] d);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    model_next(r, w, a, d);
    edge_mem();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic acc(input int i, input logic w, input logic [11:0] ad, input logic [11:0] dt,
                     output logic [11:0] rdo, output logic [2:0] ero);
    drive(3'b001 << i, 3'(w) << i, 36'(ad) << (i*12), 36'(dt) << (i*12));
    drive(3'b000, 3'b000, '0, '0);
    rdo = bus.rdata;
    ero = bus.err;
    drive(3'b000, 3'b000, '0, '0);
  endtask

  function automatic logic [11:0] ra();
    return ($urandom_range(0, 9) == 0) ? 12'($urandom_range(250, 260)) : 12'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i]  = 12'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[12'h010]  = 12'hABC;
    ref_mem[12'h010] = 12'hABC;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.mem_data_out = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_mwe", 32'(bus.mem_write_enable), 0);
    check("rst_maddr", 32'(bus.mem_addr), 0);
    edge_mem();
    @(negedge clk);
    reset = 1'b0;
    check_cycle();

    acc(0, 1'b0, 12'h010, 12'h000, rd, er);
    check("fetch_rdata", 32'(rd), 32'h0ABC);

    mwe_before = mwe_cnt;
    acc(1, 1'b1, 12'h020, 12'h5A5, rd, er);
    acc(1, 1'b0, 12'h020, 12'h000, rd, er);
    check("wr_rd_data", 32'(rd), 32'h05A5);
    check("wr_pulses", 32'(mwe_cnt - mwe_before), 1);

    mwe_before = mwe_cnt;
    acc(1, 1'b1, 12'h0FF, 12'h123, rd, er);
    check("oor_err", 32'(er), 32'b010);
    check("oor_rdata", 32'(rd), 0);
    check("oor_no_wr", 32'(mwe_cnt - mwe_before), 0);

    for (int c = 0; c < 40; c++)
      drive(3'b111, 3'($urandom), {ra(), ra(), ra()}, 36'({$urandom, $urandom}));

    drive(3'b000, 3'b000, '0, '0);
    drive(3'b010, 3'b010, 36'h123 << 12, 36'h777 << 12);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_gnt", 32'(bus.gnt), 0);
    check("mid_done", 32'(bus.done), 0);
    check("mid_mwe", 32'(bus.mem_write_enable), 0);
    check("mid_maddr", 32'(bus.mem_addr), 0);
    m_phase = 0; cnt_d = 0; cnt_f = 0;
    bus.req = '0;
    edge_mem();
    @(negedge clk);
    reset = 1'b0;
    check_cycle();
    check("mid_no_write", 32'(tb_mem[12'h123]), 32'(ref_mem[12'h123]));
    acc(0, 1'b0, 12'h010, 12'h000, rd, er);
    check("post_rst_rd", 32'(rd), 32'h0ABC);

    drive(3'b001, 3'b000, 36'h005, '0);
    drive(3'b000, 3'b000, '0, '0);
    drive(3'b010, 3'b000, 36'h007 << 12, '0);
    drive(3'b000, 3'b000, '0, '0);
    drive(3'b000, 3'b000, '0, '0);
    for (int c = 0; c < 18; c++)
      drive(3'b110, 3'b000, {ra(), ra(), ra()}, '0);
    drive(3'b000, 3'b000, '0, '0);

    for (int c = 0; c < 600; c++)
      drive(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom), 3'($urandom),
            {ra(), ra(), ra()}, 36'({$urandom, $urandom}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
